// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache refill/writeback bus: responder state encoding,
// line geometry and the address-to-word-index mapping used by both bus ends.
package cache_bus_pkg;

  localparam int BEATS      = 2;
  localparam int LINE_BYTES = 16;
  localparam int DATA_W     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BEAT,
    ST_WR_RESP,
    ST_RD_WAIT,
    ST_RD_BEAT0,
    ST_RD_BEAT1
  } bus_state_t;

  // Word index of the first beat of the line holding addr; callers truncate to memory depth.
  function automatic logic [63:0] line_word_base(input logic [63:0] addr);
    return {3'b000, addr[63:4], 1'b0};
  endfunction

endpackage

// File: rtl/cache_bus_if.sv
// Refill/writeback bus between the data cache (master) and the memory responder (slave).
interface cache_bus_if;
  import cache_bus_pkg::*;

  logic              r_valid;
  logic [63:0]       r_raddr;
  logic              r_ready;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rlast;
  logic              w_valid;
  logic [63:0]       w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wlast;
  logic              w_ready;
  logic              b_valid;
  logic              b_ready;

  modport master (
    output r_valid, r_raddr,
    input  r_ready, r_rdata, r_rlast,
    output w_valid, w_waddr, w_wdata, w_wlast,
    input  w_ready,
    input  b_valid,
    output b_ready
  );

  modport slave (
    input  r_valid, r_raddr,
    output r_ready, r_rdata, r_rlast,
    input  w_valid, w_waddr, w_wdata, w_wlast,
    output w_ready,
    output b_valid,
    input  b_ready
  );

endinterface

// File: rtl/cache_bus_mem_array.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x 64, one write enable, registered read data.
module cache_bus_mem_array
  import cache_bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Read data only moves on re so a beat stays stable while the initiator stalls.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_bus_responder.sv
// Memory-side responder: serves 2-beat line reads and 2-beat writebacks from an
// internal RAM, serialising the two so a read after a write sees the new data.
module cache_bus_responder
  import cache_bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  cache_bus_if.slave  bus
);

  localparam int IDX_W = DEPTH_LOG2;

  bus_state_t        state, state_nxt;
  logic [IDX_W-1:0]  line_base;
  logic              beat_cnt;
  logic [3:0]        lat_cnt;
  logic [DATA_W-1:0] rdata_hold;

  logic              mem_we;
  logic              mem_re;
  logic [IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  r_idx;

  assign w_idx = IDX_W'(line_word_base(bus.w_waddr));
  assign r_idx = IDX_W'(line_word_base(bus.r_raddr));

  cache_bus_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (bus.w_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // The RAM read for each beat is issued one cycle ahead, on the transition into that beat.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = line_base | IDX_W'(beat_cnt);
    unique case (state)
      ST_IDLE: begin
        if (bus.w_valid) begin
          state_nxt = ST_WR_BEAT;
        end else if (bus.r_valid) begin
          if (RD_LATENCY == 0) begin
            state_nxt = ST_RD_BEAT0;
            mem_re    = 1'b1;
            mem_addr  = r_idx;
          end else begin
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_WR_BEAT: begin
        if (bus.w_valid) begin
          mem_we = 1'b1;
          if (bus.w_wlast || beat_cnt) state_nxt = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bus.b_ready) state_nxt = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (!bus.r_valid) begin
          state_nxt = ST_IDLE;
        end else if (lat_cnt == 4'd1) begin
          state_nxt = ST_RD_BEAT0;
          mem_re    = 1'b1;
          mem_addr  = line_base;
        end
      end
      ST_RD_BEAT0: begin
        if (!bus.r_valid) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RD_BEAT1;
          mem_re    = 1'b1;
          mem_addr  = line_base | IDX_W'(1);
        end
      end
      ST_RD_BEAT1: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_cnt   <= 1'b0;
      lat_cnt    <= '0;
      rdata_hold <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          beat_cnt <= 1'b0;
          if (!bus.w_valid && bus.r_valid) lat_cnt <= 4'(RD_LATENCY);
        end
        ST_WR_BEAT:  if (bus.w_valid) beat_cnt <= ~beat_cnt;
        ST_RD_WAIT:  lat_cnt <= lat_cnt - 4'd1;
        ST_RD_BEAT0: if (bus.r_valid) rdata_hold <= mem_rdata;
        ST_RD_BEAT1: if (bus.r_valid) rdata_hold <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Line base is plain data: captured whenever idle, consumed only by the burst it starts.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE) line_base <= bus.w_valid ? w_idx : r_idx;
  end

  assign bus.r_ready = (state == ST_RD_BEAT0) || (state == ST_RD_BEAT1);
  assign bus.r_rlast = (state == ST_RD_BEAT1);
  assign bus.r_rdata = bus.r_ready ? mem_rdata : rdata_hold;
  assign bus.w_ready = (state == ST_WR_BEAT);
  assign bus.b_valid = (state == ST_WR_RESP);

endmodule

// File: doc/cache_bus_responder.md
# cache_bus_responder

Memory-side responder for the cache refill/writeback bus. It accepts 2-beat, 16-byte-line read bursts and 2-beat writeback bursts from a DCache-style initiator, with the write-response handshake. It serves them from an internal single-port 64-bit memory with a configurable read latency. It sits between the data cache and main memory in simulation and FPGA builds, and is the responder counterpart of the cache's bus master.

## Interface

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 64-bit words (default 8 KiB).
- RD_LATENCY, 2, idle cycles between read-request acceptance and the first read beat; legal range 0..15.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- bus_r_valid  in  1  read request pending; initiator holds it until the rlast beat fires.
- bus_r_raddr  in  64  line base address; bits [3:0] ignored.
- bus_r_ready  out  1  read beat present; a beat fires on bus_r_valid & bus_r_ready.
- bus_r_rdata  out  64  read beat data.
- bus_r_rlast  out  1  final read beat; high only together with bus_r_ready on beat 1.
- bus_w_valid  in  1  write beat valid.
- bus_w_waddr  in  64  line base address, constant for both beats; bits [3:0] ignored.
- bus_w_wdata  in  64  write beat data; full 64-bit write, no strobes.
- bus_w_wlast  in  1  final write beat.
- bus_w_ready  out  1  write beat accepted on bus_w_valid & bus_w_ready.
- bus_b_valid  out  1  write response.
- bus_b_ready  in  1  initiator accepts the write response.

## Operation

- Word index = addr[DEPTH_LOG2+2:3] with addr[3] forced to 0 for the base. Beat k (k = 0, 1) targets index base+k. Higher address bits are ignored, so addresses wrap modulo the memory size.
- Memory contents are not reset.
- States: IDLE, WR_BEAT, WR_RESP, RD_WAIT, RD_BEAT0, RD_BEAT1.
- IDLE:
  - bus_w_valid → latch waddr, go to WR_BEAT.
  - Otherwise bus_r_valid → latch raddr, load the latency counter with RD_LATENCY, go to RD_WAIT. If RD_LATENCY = 0, go directly to RD_BEAT0.
  - Write has priority when both are asserted; the read stays pending because the initiator holds bus_r_valid.
- WR_BEAT:
  - bus_w_ready = 1. On each fire, write wdata to mem[base+beat] and increment the beat count.
  - Leave for WR_RESP on a fire with wlast = 1, or on the second fire regardless of wlast.
  - bus_w_valid low: wait, no write.
- WR_RESP:
  - bus_b_valid = 1, held until bus_b_ready.
  - On the b fire, go to IDLE.
- RD_WAIT: decrement the counter; at 0 go to RD_BEAT0. The memory read for index base is issued in the last wait cycle.
- RD_BEAT0: bus_r_ready = 1, rdata = mem[base], rlast = 0. On fire, go to RD_BEAT1.
- RD_BEAT1: bus_r_ready = 1, rdata = mem[base+1], rlast = 1. On fire, go to IDLE.
- bus_r_valid low in RD_WAIT or either beat state is a protocol violation: abort to IDLE, drive no beat.
- A read issued after a write completes returns the written data; ordering is guaranteed by serialisation.
- bus_r_rdata holds its last beat value outside beats.

## Timing

- Reset values: bus_r_ready 0, bus_r_rdata 0, bus_r_rlast 0, bus_w_ready 0, bus_b_valid 0, state IDLE, counters 0.
- Reset mid-operation aborts any burst; all outputs take reset values on the next cycle.
- All outputs are decoded from registered state or come from registers; there is no combinational input-to-output path.
- Read: request sampled in IDLE at cycle 0 → beat0 at cycle RD_LATENCY+1 → beat1 at cycle RD_LATENCY+2 → IDLE at cycle RD_LATENCY+3.
- Write: sampled at cycle 0 → w_ready at cycles 1–2 with continuous w_valid → b_valid at cycle 3. With b_ready already high, b fires at cycle 3 and IDLE is reached at cycle 4.
- Concurrent write and read (victim writeback plus refill): the first read beat appears at cycle 4 + RD_LATENCY + 1 at the earliest.
- Earliest new request acceptance is in the IDLE cycle after the prior burst ends; no bubble is required beyond that cycle.

## Structure

- Shared package `cache_bus_pkg`:
  - State enum.
  - Beat count (2), line bytes (16), data width (64).
  - The address-to-index function.
  - The package is reused by the cache side.
- Sub-module `cache_bus_mem_array`: single-port synchronous RAM, 2^DEPTH_LOG2 × 64, with one write-enable and registered read data. The responder owns all sequencing.

## Test plan

- Reset: all outputs 0 after reset; no beats and no b_valid while inputs stay idle.
- Write then read, RD_LATENCY=2: write 0x80 with beats 0xAAAA… and 0xBBBB… → w_ready at cycles 1–2, b_valid at cycle 3. Then read 0x80 → r_ready at cycles 3 and 4 after sampling, rdata 0xAAAA… then 0xBBBB…, rlast only on the second beat.
- Concurrent write to 0x100 and read of 0x200 (0x200 preloaded with C, D): the write completes first with b fire, then the read returns C, D; 0x100 then reads back the written data.
- Address handling: reading 0x88 returns the same line as 0x80. With DEPTH_LOG2=10, address 0x2000 aliases 0x0.
- RD_LATENCY=0: first beat at cycle 1. Holding w_valid low for 2 cycles between beats → w_ready stays high and the second write is accepted late and correctly.
- Reset asserted during RD_BEAT0 → outputs 0 next cycle. A subsequent read of 0x80 is served normally with full latency.
